// File: rtl/seq_divide_pkg.sv
// Shared FSM encoding and sizing helpers for the sequential restoring divider.
package seq_divide_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } div_state_e;

   // Counter must hold the value WidthA itself, not just WidthA-1.
   function automatic int cnt_width(input int width_a);
      return $clog2(width_a + 1);
   endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module seq_div_step
   import seq_divide_pkg::*;
#(
   parameter int WidthB = 32
) (
   input  logic [WidthB:0]   rem,
   input  logic              q_msb,
   input  logic [WidthB-1:0] divisor,
   output logic [WidthB:0]   rem_next,
   output logic              q_bit
);

   logic [WidthB:0] shifted;
   logic [WidthB:0] trial;

   always_comb begin
      shifted  = {rem[WidthB-1:0], q_msb};
      trial    = shifted - {1'b0, divisor};
      // A set rem MSB means the shifted value spilled past WidthB+1 bits and exceeds any divisor.
      q_bit    = rem[WidthB] | ~trial[WidthB];
      rem_next = q_bit ? trial : shifted;
   end

endmodule

// File: rtl/seq_divide.sv
// Sequential restoring divider, one quotient bit per clock, start/finish handshake.
// Define SEQ_DIVIDE_SIGNED_EN for two's-complement operands (adds a sign-fixup FIX cycle).
module seq_divide
   import seq_divide_pkg::*;
#(
   parameter int WidthA = 32,
   parameter int WidthB = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [WidthA-1:0] a_i,
   input  logic [WidthB-1:0] b_i,
   input  logic              start_i,
   output logic [WidthA-1:0] q_o,
   output logic [WidthB-1:0] r_o,
   output logic              div_zero_o,
   output logic              finish_o
);

   localparam int CntW = cnt_width(WidthA);
   localparam int ExtW = (WidthA > WidthB) ? WidthA : WidthB;

   div_state_e        state_q, state_d;
   logic [WidthB:0]   rem_q, rem_step;
   logic [WidthA-1:0] quo_q;
   logic [WidthB-1:0] dvs_q;
   logic [CntW-1:0]   cnt_q;
   logic              div_zero_q, finish_q, finish_d;
   logic              q_bit, b_zero, do_step;
   logic [WidthA-1:0] a_mag;
   logic [WidthB-1:0] b_mag;
   logic [ExtW-1:0]   a_ext;

   assign b_zero = (b_i == '0);

`ifdef SEQ_DIVIDE_SIGNED_EN
   logic neg_quo_q, neg_rem_q, do_fix;

   assign a_mag = a_i[WidthA-1] ? -a_i : a_i;
   assign b_mag = b_i[WidthB-1] ? -b_i : b_i;
   assign a_ext = ExtW'($signed(a_i));
`else
   assign a_mag = a_i;
   assign b_mag = b_i;
   assign a_ext = ExtW'(a_i);
`endif

   seq_div_step #(
      .WidthB (WidthB)
   ) u_step (
      .rem      (rem_q),
      .q_msb    (quo_q[WidthA-1]),
      .divisor  (dvs_q),
      .rem_next (rem_step),
      .q_bit    (q_bit)
   );

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state: a new start always wins, aborting whatever is in flight.
   always_comb begin
      state_d = state_q;
      if (start_i) begin
         state_d = b_zero ? IDLE : RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (cnt_q == CntW'(1)) begin
`ifdef SEQ_DIVIDE_SIGNED_EN
                  state_d = FIX;
`else
                  state_d = IDLE;
`endif
               end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs / datapath controls
   always_comb begin
      do_step  = ~start_i & (state_q == RUN);
`ifdef SEQ_DIVIDE_SIGNED_EN
      do_fix   = ~start_i & (state_q == FIX);
`endif
      finish_d = ~start_i & (state_d == IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         cnt_q      <= '0;
         div_zero_q <= 1'b0;
         finish_q   <= 1'b1;
`ifdef SEQ_DIVIDE_SIGNED_EN
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
`endif
      end else begin
         finish_q <= finish_d;
         if (start_i) begin
            div_zero_q <= b_zero;
            cnt_q      <= CntW'(WidthA);
`ifdef SEQ_DIVIDE_SIGNED_EN
            // Divide-by-zero result is already final, so no sign fixup applies.
            neg_quo_q  <= ~b_zero & (a_i[WidthA-1] ^ b_i[WidthB-1]);
            neg_rem_q  <= ~b_zero & a_i[WidthA-1];
`endif
            if (b_zero) begin
               quo_q <= '1;
               rem_q <= {1'b0, a_ext[WidthB-1:0]};
            end else begin
               quo_q <= a_mag;
               rem_q <= '0;
               dvs_q <= b_mag;
            end
         end else if (do_step) begin
            rem_q <= rem_step;
            quo_q <= {quo_q[WidthA-2:0], q_bit};
            cnt_q <= cnt_q - CntW'(1);
         end
`ifdef SEQ_DIVIDE_SIGNED_EN
         else if (do_fix) begin
            if (neg_quo_q) quo_q <= -quo_q;
            if (neg_rem_q) rem_q <= {1'b0, -rem_q[WidthB-1:0]};
         end
`endif
      end
   end

   assign q_o        = quo_q;
   assign r_o        = rem_q[WidthB-1:0];
   assign div_zero_o = div_zero_q;
   assign finish_o   = finish_q;

endmodule

// File: tb/tb_seq_divide.sv
// Self-checking bench for seq_divide: directed vector table, hand sequences, random vs. arithmetic model.
module tb_seq_divide;

   localparam int W = 32;
`ifdef SEQ_DIVIDE_SIGNED_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic [W-1:0]  a_i = '0;
   logic [W-1:0]  b_i = '0;
   logic          start_i = 1'b0;
   logic [W-1:0]  q_o;
   logic [W-1:0]  r_o;
   logic          div_zero_o;
   logic          finish_o;

   int total = 0;
   int bad   = 0;

   seq_divide #(.WidthA(W), .WidthB(W)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .a_i        (a_i),
      .b_i        (b_i),
      .start_i    (start_i),
      .q_o        (q_o),
      .r_o        (r_o),
      .div_zero_o (div_zero_o),
      .finish_o   (finish_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string        name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Caller sits #1 after a rising edge with the unit idle.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic fin_after_start);
      a_i = a; b_i = b; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      fin_after_start = finish_o;
      lat = 0;
      while (!finish_o && lat < 200) begin
         @(posedge clk_i); #1;
         lat++;
      end
   endtask

   task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
      int   lat;
      logic f0;
      run_op(a, b, lat, f0);
      chk({name, ".drop"}, 64'(f0), 64'(0));
      chk({name, ".lat"}, 64'(lat), 64'((b == '0) ? 1 : LAT));
      chk({name, ".q"}, 64'(q_o), 64'(eq));
      chk({name, ".r"}, 64'(r_o), 64'(er));
      chk({name, ".dz"}, 64'(div_zero_o), 64'(edz));
   endtask

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
      if (b == '0) begin
         q = '1;
         r = a;
      end else begin
`ifdef SEQ_DIVIDE_SIGNED_EN
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
`else
         q = a / b;
         r = a % b;
`endif
      end
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int           lat;
      logic         f0;
      logic [W-1:0] ra, rb, eq, er;

      vecs.push_back('{name:"basic",  a:32'd100,        b:32'd7,          q:32'd14,         r:32'd2,    dz:1'b0});
      vecs.push_back('{name:"max_1",  a:32'hFFFF_FFFF,  b:32'd1,          q:32'hFFFF_FFFF,  r:32'd0,    dz:1'b0});
      vecs.push_back('{name:"small",  a:32'd5,          b:32'd9,          q:32'd0,          r:32'd5,    dz:1'b0});
      vecs.push_back('{name:"msb_eq", a:32'h8000_0000,  b:32'h8000_0000,  q:32'd1,          r:32'd0,    dz:1'b0});
      vecs.push_back('{name:"dz",     a:32'd1234,       b:32'd0,          q:32'hFFFF_FFFF,  r:32'd1234, dz:1'b1});
`ifdef SEQ_DIVIDE_SIGNED_EN
      vecs.push_back('{name:"neg7_2", a:32'hFFFF_FFF9,  b:32'd2,          q:32'hFFFF_FFFD,  r:32'hFFFF_FFFF, dz:1'b0});
      vecs.push_back('{name:"7_neg2", a:32'd7,          b:32'hFFFF_FFFE,  q:32'hFFFF_FFFD,  r:32'd1,    dz:1'b0});
      vecs.push_back('{name:"ovf",    a:32'h8000_0000,  b:32'hFFFF_FFFF,  q:32'h8000_0000,  r:32'd0,    dz:1'b0});
`endif

      // Reset state, with start held during reset (reset must win).
      start_i = 1'b1; a_i = 32'd5; b_i = 32'd1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst.finish", 64'(finish_o), 64'(1));
      chk("rst.q", 64'(q_o), 64'(0));
      chk("rst.r", 64'(r_o), 64'(0));
      chk("rst.dz", 64'(div_zero_o), 64'(0));
      start_i = 1'b0;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("rst.idle", 64'(finish_o), 64'(1));

      foreach (vecs[i]) check_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

      // Results hold in IDLE.
      check_op("hold", 32'd77, 32'd10, 32'd7, 32'd7, 1'b0);
      repeat (4) @(posedge clk_i);
      #1;
      chk("hold.q", 64'(q_o), 64'(7));
      chk("hold.r", 64'(r_o), 64'(7));
      chk("hold.fin", 64'(finish_o), 64'(1));

      // Restart 10 cycles into 1000/3.
      a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk_i);
      #1;
      chk("restart.busy", 64'(finish_o), 64'(0));
      check_op("restart", 32'd50, 32'd6, 32'd8, 32'd2, 1'b0);

      // Reset 5 cycles into an operation.
      a_i = 32'd999; b_i = 32'd4; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("midrst.finish", 64'(finish_o), 64'(1));
      chk("midrst.q", 64'(q_o), 64'(0));
      chk("midrst.r", 64'(r_o), 64'(0));
      #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("midrst.idle", 64'(finish_o), 64'(1));

      // Divide-by-zero followed straight by a normal divide (flag must clear).
      check_op("dz2", 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1);
      check_op("after_dz", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0);

      // Random operands against the arithmetic model.
      for (int n = 0; n < 150; n++) begin
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1, 2:    rb = 32'($urandom_range(1, 15));
            3:       rb = $urandom >> $urandom_range(0, 31);
            4:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: rb = $urandom;
         endcase
         if (rb == '0 && $urandom_range(0, 1) == 0) rb = 32'd1;
         model(ra, rb, eq, er);
         run_op(ra, rb, lat, f0);
         chk("rnd.lat", 64'(lat), 64'((rb == '0) ? 1 : LAT));
         chk("rnd.q", 64'(q_o), 64'(eq));
         chk("rnd.r", 64'(r_o), 64'(er));
         chk("rnd.dz", 64'(div_zero_o), 64'(rb == '0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_divide.md
# seq_divide

Sequential restoring divider that returns quotient and remainder for a WidthA-bit dividend and a WidthB-bit divisor. It retires one quotient bit per clock, so an unsigned divide takes WidthA cycles. It is the inverse companion of the team's shift-and-add sequential multiplier. It uses the same start/finish handshake, so both units sit interchangeably behind one arithmetic-unit sequencer.

## Interface
- WidthA, 32, dividend and quotient width
- WidthB, 32, divisor and remainder width
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset, asynchronous assert, active-low
- a_i  input  WidthA  dividend, sampled only on a start cycle
- b_i  input  WidthB  divisor, sampled only on a start cycle
- start_i  input  1  single-cycle request; accepted on any cycle, including while busy
- q_o  output  WidthA  quotient, valid while finish_o=1
- r_o  output  WidthB  remainder, valid while finish_o=1
- div_zero_o  output  1  last accepted request had divisor 0; valid while finish_o=1
- finish_o  output  1  high when idle/done, low while busy

## Operation
- FSM states: IDLE, RUN, FIX. FIX exists only in the signed build.
- Reset values: state IDLE, q_o 0, r_o 0, div_zero_o 0, finish_o 1.
- start_i, b_i≠0:
  - Latch divisor and load quotient register with dividend.
  - Clear partial remainder, which is WidthB+1 bits.
  - Set count = WidthA and go to RUN.
- RUN, each cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem − divisor, computed at WidthB+1 bits.
  - If trial is non-negative, rem takes trial and quo[0] = 1.
  - Decrement count.
  - At count 1 → 0, go to IDLE (unsigned build) or FIX (signed build).
- start_i, b_i=0:
  - Set div_zero_o = 1.
  - q_o = all ones.
  - r_o = a_i zero-extended or truncated to WidthB.
  - Go straight to IDLE; no iteration.
- start_i while busy: abort the current operation and restart with the new operands. Partial results are discarded.
- q_o and r_o hold their value in IDLE until the next start is accepted. During RUN they show internal partial values and are don't-care.
- Remainder always satisfies r < divisor. Exception: divide-by-zero.

## Timing
- Start accepted on edge N. finish_o drops after edge N.
- Unsigned result: finish_o rises after edge N+WidthA.
- Signed result: finish_o rises after edge N+WidthA+1.
- Divide-by-zero: finish_o rises after edge N+1.
- finish_o is a registered level, not a pulse. The consumer samples q_o and r_o on the first cycle finish_o is high.
- Reset asserted mid-operation: immediately go to IDLE with all outputs at reset values. No result is produced.
- start_i and reset together: reset wins.

## Configuration
- Macro: SEQ_DIVIDE_SIGNED_EN.
- Defined:
  - a_i and b_i are two's complement.
  - Operand magnitudes are taken on capture.
  - FIX state negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative. The remainder takes the dividend's sign.
  - Divide-by-zero: q = −1, r = dividend.
  - Overflow case (most-negative ÷ −1, WidthA = WidthB): q = most-negative, r = 0. No flag is raised.
- Undefined: operands are unsigned and there is no FIX state.

## Structure
- seq_divide_pkg holds:
  - The state enum typedef: IDLE, RUN, FIX.
  - A function computing the count width, $clog2(WidthA+1).
- One sub-module, seq_div_step: purely combinational, one iteration.
  - Inputs: rem, quotient MSB, divisor.
  - Outputs: next rem and the quotient bit.
  - Kept separate so it can be reused by a future radix-4 variant.

## Test plan
- Unsigned basic: a=100, b=7 → q=14, r=2, div_zero_o=0. finish_o low for exactly 32 cycles.
- Boundaries, unsigned:
  - a=0xFFFFFFFF, b=1 → q=0xFFFFFFFF, r=0.
  - a=5, b=9 → q=0, r=5.
  - a=b=0x80000000 → q=1, r=0.
- Divide-by-zero: a=1234, b=0 → q=0xFFFFFFFF, r=1234, div_zero_o=1, finish_o high after 1 cycle.
- Restart: new start 10 cycles into 1000÷3, with a=50, b=6 → q=8, r=2, 32 cycles after the second start.
- Reset 5 cycles into an operation → finish_o=1, q_o=0, r_o=0 immediately.
- Signed (macro on):
  - −7÷2 → q=−3, r=−1.
  - 7÷−2 → q=−3, r=1.
  - 0x80000000÷−1 → q=0x80000000, r=0.
  - Latency 33 cycles.
